// File: rtl/fp2_pkg.sv
// fp2_pkg: shared Fp2 limb width, subtraction pipeline latency and result types.
package fp2_pkg;
    localparam int FP_W = 255;
    localparam int FP2_SUB_LAT = 8;
    localparam int TAG_W = 4;
    typedef logic [TAG_W-1:0] tag_t;
    typedef struct packed {
        logic [FP_W-1:0] re;
        logic [FP_W-1:0] im;
    } fp2_t;
    typedef struct packed {
        fp2_t d;
        tag_t tag;
    } res_t;
endpackage

// File: rtl/fp2_sub_issue_if.sv
// fp2_sub_issue_if: request, fp2_sub pipeline and result signals of the issue block.
interface fp2_sub_issue_if;
    import fp2_pkg::*;
    logic in_valid, in_ready;
    logic [FP_W-1:0] in_a1, in_b1, in_a2, in_b2;
    tag_t in_tag;
    logic [FP_W-1:0] sub_a1, sub_b1, sub_a2, sub_b2;
    logic [FP_W-1:0] sub_d1, sub_d2;
    logic out_valid, out_ready;
    logic [FP_W-1:0] out_d1, out_d2;
    tag_t out_tag;
    modport master (
        output in_valid, in_a1, in_b1, in_a2, in_b2, in_tag, sub_d1, sub_d2, out_ready,
        input in_ready, sub_a1, sub_b1, sub_a2, sub_b2, out_valid, out_d1, out_d2, out_tag
    );
    modport slave (
        input in_valid, in_a1, in_b1, in_a2, in_b2, in_tag, sub_d1, sub_d2, out_ready,
        output in_ready, sub_a1, sub_b1, sub_a2, sub_b2, out_valid, out_d1, out_d2, out_tag
    );
endinterface

// File: rtl/fp2_res_fifo.sv
// fp2_res_fifo: DEPTH-entry result FIFO; writes to a full FIFO are dropped and latch err.
module fp2_res_fifo
    import fp2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  res_t                     wr_data,
    input  logic                     rd,
    output res_t                     rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);
    res_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;

    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign rd_data = mem[rp];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp <= '0;
            rp <= '0;
            count <= '0;
            err <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= wr_data;
                wp <= wp + AW'(1);
            end
            if (rd_ok) rp <= rp + AW'(1);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            if (wr && full) err <= 1'b1;
        end
endmodule

// File: rtl/fp2_sub_issue.sv
// fp2_sub_issue: credit-based valid/ready front-end and result collector for fp2_sub.
// Define FP2_SUB_ISSUE_PERF_EN to add saturating issue/stall performance counters.
module fp2_sub_issue
    import fp2_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SUB_LAT = FP2_SUB_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    fp2_sub_issue_if.slave bus
`ifdef FP2_SUB_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall_in,
    output logic [31:0] perf_stall_out
`endif
);
    localparam int CW = $clog2(SUB_LAT + DEPTH + 2);
    localparam int FW = $clog2(DEPTH) + 1;

    logic run, acc_v, accept, pop, fifo_full, fifo_empty, ovf;
    tag_t acc_tag;
    logic [SUB_LAT-1:0] pipe_v;
    tag_t [SUB_LAT-1:0] pipe_tag;
    logic [FW-1:0] fifo_count;
    logic [CW-1:0] used;
    res_t wr_res, head;

    // acc_v is the sub_* register stage; pipe_v tracks the SUB_LAT stages inside fp2_sub
    always_comb begin
        used = CW'(acc_v) + CW'(fifo_count);
        for (int i = 0; i < SUB_LAT; i++) used += CW'(pipe_v[i]);
    end

    assign bus.in_ready = run && !ovf && used < CW'(DEPTH);
    assign accept = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            run <= 1'b0;
            acc_v <= 1'b0;
            acc_tag <= '0;
            pipe_v <= '0;
            pipe_tag <= '0;
            bus.sub_a1 <= '0;
            bus.sub_b1 <= '0;
            bus.sub_a2 <= '0;
            bus.sub_b2 <= '0;
        end else begin
            run <= 1'b1;
            acc_v <= accept;
            pipe_v <= {pipe_v[SUB_LAT-2:0], acc_v};
            pipe_tag <= {pipe_tag[SUB_LAT-2:0], acc_tag};
            if (accept) begin
                acc_tag <= bus.in_tag;
                bus.sub_a1 <= bus.in_a1;
                bus.sub_b1 <= bus.in_b1;
                bus.sub_a2 <= bus.in_a2;
                bus.sub_b2 <= bus.in_b2;
            end
        end

    assign wr_res = {bus.sub_d1, bus.sub_d2, pipe_tag[SUB_LAT-1]};

    fp2_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (pipe_v[SUB_LAT-1]),
        .wr_data (wr_res),
        .rd      (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .err     (ovf)
    );

    assign bus.out_valid = !fifo_empty;
    assign {bus.out_d1, bus.out_d2, bus.out_tag} = head;

    // credits make a result arriving at a full FIFO impossible
    assert property (@(posedge clk) disable iff (!rst_n) !(pipe_v[SUB_LAT-1] && fifo_full));

`ifdef FP2_SUB_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall_in <= '0;
            perf_stall_out <= '0;
        end else begin
            if (accept && !(&perf_issued)) perf_issued <= perf_issued + 32'd1;
            if (bus.in_valid && !bus.in_ready && !(&perf_stall_in)) perf_stall_in <= perf_stall_in + 32'd1;
            if (bus.out_valid && !bus.out_ready && !(&perf_stall_out)) perf_stall_out <= perf_stall_out + 32'd1;
        end
`endif
endmodule
